// File: rtl/pulsador_note_bank.sv
// pulsador_note_bank
//
// Multi-channel button-gated note generator. Each active-low push-button
// (pull-up pin) is synchronised, debounced and extended by a release
// sustain. The resulting gate enables a half-period divider that produces
// that channel's square-wave tone. The tones are merged into one
// registered audio output, using either mono lowest-index priority or an
// OR mix.
//
// Ports
//   clockIn    in   1          base clock (25 kHz nominal)
//   reset      in   1          synchronous, active-high reset
//   pulsadores in   NUM_NOTES  button pins, low = pressed
//   modulador  in   7          vibrato offset added to every half-period reload
//   ondaOut    out  1          registered audio square wave
//   notaActiva out  NUM_NOTES  per-channel gate (pressed or sustaining)
//   notaIdx    out  4          channel driving ondaOut in mono mode, else 0
//
// Parameters
//   NUM_NOTES     channel count (1..16)
//   CNT_W         half-period / divider counter width (>= 7)
//   HALF_PERIODS  packed half-periods, channel 0 in the LSBs
//   DEBOUNCE      stable cycles needed to accept a pin change (>= 1)
//   SUSTAIN       cycles a note keeps sounding after release (0 = none)
//   MODE          0 = mono lowest-index priority, 1 = OR of all gated tones

module pulsador_note_bank #(
   parameter int NUM_NOTES = 4,
   parameter int CNT_W     = 16,
   parameter logic [NUM_NOTES*CNT_W-1:0] HALF_PERIODS =
      {16'd21, 16'd24, 16'd25, 16'd28},
   parameter int DEBOUNCE  = 250,
   parameter int SUSTAIN   = 2500,
   parameter int MODE      = 0
) (
   input  logic                 clockIn,
   input  logic                 reset,
   input  logic [NUM_NOTES-1:0] pulsadores,
   input  logic [6:0]           modulador,
   output logic                 ondaOut,
   output logic [NUM_NOTES-1:0] notaActiva,
   output logic [3:0]           notaIdx
);

   // db never exceeds DEBOUNCE-1; rel never exceeds SUSTAIN.
   localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int REL_W = (SUSTAIN > 0) ? $clog2(SUSTAIN + 1) : 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
   localparam logic [REL_W-1:0] REL_LOAD = REL_W'(SUSTAIN);

   logic [NUM_NOTES-1:0] tone_vec;

   for (genvar i = 0; i < NUM_NOTES; i++) begin : g_ch
      logic             sync1;
      logic             sync2;
      logic             pressed_raw;
      logic             pressed;
      logic [DB_W-1:0]  db;
      logic [REL_W-1:0] rel;
      logic [CNT_W:0]   cnt;
      logic [CNT_W:0]   load;
      logic             tone;

      assign pressed_raw = ~sync2;

      // One extra bit so HALF_PERIODS + modulador can never wrap.
      assign load = {1'b0, HALF_PERIODS[i*CNT_W +: CNT_W]} + (CNT_W+1)'(modulador);

      // Reset parks the synchroniser at the released level so a held
      // button is only seen after the full debounce time.
      always_ff @(posedge clockIn) begin
         if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
         end else begin
            sync1 <= pulsadores[i];
            sync2 <= sync1;
         end
      end

      // Debounce and sustain share one process. A change of the
      // debounced level overrides the sustain countdown in the same
      // cycle. That lets a re-press landing on the last sustain cycle
      // keep the gate high.
      always_ff @(posedge clockIn) begin
         if (reset) begin
            pressed <= 1'b0;
            db      <= '0;
            rel     <= '0;
         end else begin
            if (rel != '0) begin
               rel <= rel - REL_W'(1);
            end
            if (pressed_raw != pressed) begin
               if (db == DB_LAST) begin
                  pressed <= pressed_raw;
                  db      <= '0;
                  rel     <= pressed_raw ? '0 : REL_LOAD;
               end else begin
                  db <= db + DB_W'(1);
               end
            end else begin
               db <= '0;
            end
         end
      end

      assign notaActiva[i] = pressed | (rel != '0);

      // While the gate is low, the counter is kept preloaded. The first
      // half-period therefore starts cleanly on the gate edge.
      always_ff @(posedge clockIn) begin
         if (reset) begin
            cnt  <= '0;
            tone <= 1'b0;
         end else if (!notaActiva[i]) begin
            cnt  <= load;
            tone <= 1'b0;
         end else if (cnt != '0) begin
            cnt <= cnt - (CNT_W+1)'(1);
         end else begin
            cnt  <= load;
            tone <= ~tone;
         end
      end

      assign tone_vec[i] = tone;
   end

   logic       sel_tone;
   logic [3:0] sel_idx;
   logic       or_mix;

   // Scanning from the top down leaves the lowest gated channel selected.
   always_comb begin
      sel_tone = 1'b0;
      sel_idx  = 4'd0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (notaActiva[i]) begin
            sel_tone = tone_vec[i];
            sel_idx  = 4'(i);
         end
      end
   end

   // A tone register still holds its last value for one cycle after its
   // gate falls, so the mix is masked by the gates.
   assign or_mix = |(tone_vec & notaActiva);

   always_ff @(posedge clockIn) begin
      if (reset) begin
         ondaOut <= 1'b0;
         notaIdx <= 4'd0;
      end else if (MODE == 0) begin
         ondaOut <= sel_tone;
         notaIdx <= sel_idx;
      end else begin
         ondaOut <= or_mix;
         notaIdx <= 4'd0;
      end
   end

endmodule

// File: tb/tb_pulsador_note_bank.sv
// Testbench for pulsador_note_bank.
// Three instances share the stimulus:
//   a: SUSTAIN=8, mono mode
//   b: SUSTAIN=0, mono mode
//   c: SUSTAIN=8, OR mode
// Half-periods: ch0=3, ch1=7, ch2=5, ch3=9. Debounce is 4 cycles.
// Resulting periods: ch0=8, ch1=16, ch2=12, ch3=20.

module tb_pulsador_note_bank;

   localparam logic [63:0] HP = {16'd9, 16'd5, 16'd7, 16'd3};

   logic       clockIn = 1'b0;
   logic       reset;
   logic [3:0] pulsadores;
   logic [6:0] modulador;

   logic       onda_a, onda_b, onda_c;
   logic [3:0] act_a, act_b, act_c;
   logic [3:0] idx_a, idx_b, idx_c;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clockIn = ~clockIn;

   pulsador_note_bank #(.NUM_NOTES(4), .CNT_W(16), .HALF_PERIODS(HP),
                        .DEBOUNCE(4), .SUSTAIN(8), .MODE(0)) dut_a (
      .clockIn(clockIn), .reset(reset), .pulsadores(pulsadores), .modulador(modulador),
      .ondaOut(onda_a), .notaActiva(act_a), .notaIdx(idx_a));

   pulsador_note_bank #(.NUM_NOTES(4), .CNT_W(16), .HALF_PERIODS(HP),
                        .DEBOUNCE(4), .SUSTAIN(0), .MODE(0)) dut_b (
      .clockIn(clockIn), .reset(reset), .pulsadores(pulsadores), .modulador(modulador),
      .ondaOut(onda_b), .notaActiva(act_b), .notaIdx(idx_b));

   pulsador_note_bank #(.NUM_NOTES(4), .CNT_W(16), .HALF_PERIODS(HP),
                        .DEBOUNCE(4), .SUSTAIN(8), .MODE(1)) dut_c (
      .clockIn(clockIn), .reset(reset), .pulsadores(pulsadores), .modulador(modulador),
      .ondaOut(onda_c), .notaActiva(act_c), .notaIdx(idx_c));

   typedef struct {
      logic       rst;
      logic [3:0] pins;
      logic [3:0] act;
      logic [3:0] idx;
      logic       onda;
   } vec_t;

   vec_t vecs[17];

   function automatic logic sig(input int w);
      case (w)
         0:       return onda_a;
         1:       return onda_b;
         default: return onda_c;
      endcase
   endfunction

   function automatic logic gate(input int w, input int ch);
      case (w)
         0:       return act_a[ch];
         1:       return act_b[ch];
         default: return act_c[ch];
      endcase
   endfunction

   task automatic step();
      @(posedge clockIn);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic wait_level(input string name, input int w, input logic level,
                             input int bound, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (sig(w) != level && n < bound);
      if (sig(w) != level) timeout(name);
   endtask

   task automatic wait_gate(input string name, input int w, input int ch,
                            input logic level, input int bound, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (gate(w, ch) != level && n < bound);
      if (gate(w, ch) != level) timeout(name);
   endtask

   // Called on the first sample of a run; returns the run length and
   // leaves the bench on the first sample of the opposite level.
   task automatic measure_run(input string name, input int w, input logic level,
                              output int len);
      len = 1;
      forever begin
         step();
         if (sig(w) != level) break;
         len++;
         if (len > 100) begin
            timeout(name);
            break;
         end
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      pulsadores = 4'b1111;
      modulador  = 7'd0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int trans;
      int drops;
      logic prev;

      // Reset with all pins held low, then release: gates appear after exactly 6 edges.
      vecs[0]  = '{1'b1, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[1]  = '{1'b1, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[2]  = '{1'b0, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[3]  = '{1'b0, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[4]  = '{1'b0, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[5]  = '{1'b0, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[6]  = '{1'b0, 4'b0000, 4'h0, 4'd0, 1'b0};
      vecs[7]  = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b0};
      vecs[8]  = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b0};
      vecs[9]  = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b0};
      vecs[10] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b0};
      vecs[11] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b0};
      vecs[12] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b1};
      vecs[13] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b1};
      vecs[14] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b1};
      vecs[15] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b1};
      vecs[16] = '{1'b0, 4'b0000, 4'hF, 4'd0, 1'b0};

      modulador = 7'd0;
      for (int v = 0; v < 17; v++) begin
         reset      = vecs[v].rst;
         pulsadores = vecs[v].pins;
         step();
         check($sformatf("vec%0d_act", v),  int'(act_a), int'(vecs[v].act));
         check($sformatf("vec%0d_idx", v),  int'(idx_a), int'(vecs[v].idx));
         check($sformatf("vec%0d_onda", v), int'(onda_a), int'(vecs[v].onda));
      end

      // Glitch shorter than the debounce time is ignored.
      do_reset();
      pulsadores = 4'b1101;
      repeat (3) step();
      pulsadores = 4'b1111;
      for (int s = 0; s < 10; s++) begin
         step();
         check("glitch_gate", int'(act_a), 0);
      end

      // Debounced press, first tone edge and period of channel 1.
      pulsadores = 4'b1101;
      wait_gate("press_gate", 0, 1, 1'b1, 20, n);
      check("press_latency", n, 6);
      wait_level("tone1_first", 0, 1'b1, 30, n);
      check("tone1_first_high", n, 9);
      measure_run("tone1_hi", 0, 1'b1, n);
      check("tone1_high_len", n, 8);
      measure_run("tone1_lo", 0, 1'b0, n);
      check("tone1_low_len", n, 8);
      check("tone1_idx", int'(idx_a), 1);

      // Release after 40 gated cycles; sustain holds the gate 8 more cycles.
      repeat (15) step();
      pulsadores = 4'b1111;
      for (int s = 1; s <= 13; s++) begin
         step();
         check($sformatf("sustain_hold%0d", s), int'(act_a[1]), 1);
      end
      step();
      check("sustain_end", int'(act_a[1]), 0);
      step();
      check("sustain_onda_off", int'(onda_a), 0);
      check("sustain_idx_off", int'(idx_a), 0);

      // Re-gating starts again from tone = 0.
      pulsadores = 4'b1101;
      wait_gate("regate", 0, 1, 1'b1, 20, n);
      check("regate_latency", n, 6);
      wait_level("regate_tone", 0, 1'b1, 30, n);
      check("regate_first_high", n, 9);

      // A re-press lands on the last sustain cycle: the gate never drops
      // and the divider keeps its phase, with toggles every 8 cycles.
      pulsadores = 4'b1111;
      prev  = onda_a;
      trans = 0;
      drops = 0;
      for (int s = 1; s <= 30; s++) begin
         step();
         if (s == 8) pulsadores = 4'b1101;
         if (!act_a[1]) drops++;
         if (onda_a != prev) begin
            trans++;
            check($sformatf("repress_phase_s%0d", s), s % 8, 0);
         end
         prev = onda_a;
      end
      check("repress_gate_drops", drops, 0);
      check("repress_transitions", trans, 3);

      // Mono priority: channels 0 and 2 held, then channel 0 released (no sustain).
      do_reset();
      pulsadores = 4'b1010;
      wait_gate("mono_gate", 1, 0, 1'b1, 20, n);
      check("mono_latency", n, 6);
      wait_level("mono_first", 1, 1'b1, 30, n);
      check("mono_first_high", n, 5);
      measure_run("mono_hi", 1, 1'b1, n);
      check("mono_ch0_high", n, 4);
      measure_run("mono_lo", 1, 1'b0, n);
      check("mono_ch0_low", n, 4);
      check("mono_idx0", int'(idx_b), 0);
      pulsadores = 4'b1011;
      wait_gate("mono_rel", 1, 0, 1'b0, 20, n);
      check("mono_release_latency", n, 6);
      check("mono_idx_before", int'(idx_b), 0);
      step();
      check("mono_idx_after", int'(idx_b), 2);
      wait_level("mono_ch2_fall", 1, 1'b0, 30, n);
      wait_level("mono_ch2_rise", 1, 1'b1, 30, n);
      measure_run("mono_ch2_hi", 1, 1'b1, n);
      check("mono_ch2_high", n, 6);
      measure_run("mono_ch2_lo", 1, 1'b0, n);
      check("mono_ch2_low", n, 6);

      // Reset asserted mid-note silences the output one edge later.
      check("midreset_pre", int'(onda_b), 1);
      reset = 1'b1;
      step();
      check("midreset_onda", int'(onda_b), 0);
      check("midreset_act", int'(act_b), 0);
      reset = 1'b0;

      // OR mode: channels 0 and 3, compared with the ideal square waves.
      do_reset();
      pulsadores = 4'b0110;
      wait_gate("or_gate", 2, 0, 1'b1, 20, n);
      check("or_latency", n, 6);
      check("or_act", int'(act_c), 4'b1001);
      for (int k = 1; k <= 60; k++) begin
         step();
         check($sformatf("or_onda_k%0d", k), int'(onda_c),
               (((k - 1) / 4) % 2) | (((k - 1) / 10) % 2));
         check($sformatf("or_idx_k%0d", k), int'(idx_c), 0);
      end

      // Vibrato: offset 4 stretches ch0 to period 16. Dropping the offset
      // mid-half-period only affects the next reload.
      do_reset();
      modulador  = 7'd4;
      pulsadores = 4'b1110;
      wait_gate("vib_gate", 0, 0, 1'b1, 20, n);
      check("vib_latency", n, 6);
      wait_level("vib_first", 0, 1'b1, 30, n);
      check("vib_first_high", n, 9);
      measure_run("vib_hi", 0, 1'b1, n);
      check("vib_high", n, 8);
      measure_run("vib_lo", 0, 1'b0, n);
      check("vib_low", n, 8);
      n = 1;
      for (int s = 0; s < 3; s++) begin
         step();
         if (onda_a) n++;
      end
      modulador = 7'd0;
      forever begin
         step();
         if (!onda_a) break;
         n++;
         if (n > 100) begin
            timeout("vib_change_hi");
            break;
         end
      end
      check("vib_change_high", n, 8);
      measure_run("vib_new_lo", 0, 1'b0, n);
      check("vib_new_low", n, 4);
      measure_run("vib_new_hi", 0, 1'b1, n);
      check("vib_new_high", n, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
